traffic_light_fsm: RTL and testbench
====================================

// Module: traffic_light_fsm
// PURPOSE
//  Main controller for the intersection. Consumes the latched pedestrian request (wr_to_fsm) from the
//  walk register. Sequences main-street and side-street lamps and the walk lamp from a 1 Hz enable.
//  Returns walk_request_reset to the walk register so a served request is cleared.
// PARAMETERS
//  T_BASE  6  main/side green duration, in ticks (legal range 1..2**CNT_W-1)
//  T_EXT   3  walk phase and side-green extension duration, in ticks
//  T_YEL   2  yellow duration, in ticks
//  CNT_W   4  width of the remaining-time counter
// PORTS
//  clk                 in   1  system clock; all state changes on posedge
//  global_reset        in   1  synchronous, active-high reset
//  tick                in   1  one-cycle enable at 1 Hz; the only event that advances time
//  wr_to_fsm           in   1  latched walk request from the walk register
//  sensor              in   1  side-street vehicle sensor (port present only with TRAFFIC_SENSOR_EN)
//  main_rgy            out  3  main-street lamps, one-hot {R,Y,G}
//  side_rgy            out  3  side-street lamps, one-hot {R,Y,G}
//  walk_lamp           out  1  pedestrian walk lamp
//  walk_request_reset  out  1  clears the walk register
// BEHAVIOUR
//  - Outputs are Moore-decoded from the state register only; there is no comb path from inputs.
//  - States and lamps (main/side/walk):
//      S_MG   001/100/0
//      S_MY   010/100/0
//      S_WALK 100/100/1
//      S_SG   100/001/0
//      S_SGX  100/001/0
//      S_SY   100/010/0
//  - Each state has a duration D: S_MG=T_BASE, S_MY=T_YEL, S_WALK=T_EXT, S_SG=T_BASE, S_SGX=T_EXT, S_SY=T_YEL.
//  - Timer rem[CNT_W-1:0]:
//      on state entry, rem loads D
//      on a cycle with tick=1 and rem>1, rem decrements
//      on a cycle with tick=1 and rem==1, the FSM transitions and rem loads the next state's D
//      cycles with tick=0 change nothing
//    Each state therefore lasts exactly D ticks.
//  - Transitions on expiry:
//      S_MG   -> S_MY
//      S_MY   -> S_WALK if wr_to_fsm==1 in the expiry cycle, else S_SG
//      S_WALK -> S_SG
//      S_SG   -> S_SGX (sensor case, see CONFIGURATION), else S_SY
//      S_SGX  -> S_SY
//      S_SY   -> S_MG
//  - walk_request_reset=1 in every cycle where state==S_WALK, else 0. Requests made during a walk are
//    absorbed by that walk. Requests made in any other state are held by the walk register until the
//    next S_MY expiry.
//  - wr_to_fsm rising in the same cycle as the S_MY expiry tick is honoured (S_WALK is taken).
//  - Reset values: state=S_MG, rem=T_BASE, main_rgy=001, side_rgy=100, walk_lamp=0, walk_request_reset=0.
//  - global_reset has priority over tick and over all transitions. Asserting it mid-phase (including
//    mid-walk) returns to the reset state on the next edge.
//  - Illegal state encodings recover to S_MG with rem=T_BASE on the next edge.
//  - Main and side lamps are never both non-red in any state.
// CONFIGURATION
//  TRAFFIC_SENSOR_EN defined:
//    - sensor port exists
//    - at S_SG expiry, sensor==1 goes to S_SGX (side green extended by T_EXT ticks); sensor==0 goes to S_SY
//  TRAFFIC_SENSOR_EN undefined:
//    - no sensor port
//    - S_SGX is unreachable; S_SG always goes to S_SY
// TESTING (defaults T_BASE=6, T_EXT=3, T_YEL=2, tick every 4 clocks)
//  1 reset, wr_to_fsm=0 for 32 ticks -> period 16 ticks (MG6, MY2, SG6, SY2); walk_lamp stays 0;
//    walk_request_reset stays 0
//  2 wr_to_fsm=1 from MG tick 3 -> after MY, 3 ticks of walk_lamp=1 with main=side=100;
//    walk_request_reset high for all 12 clocks; then SG; period 19 ticks
//  3 wr_to_fsm rises in the S_MY expiry cycle -> S_WALK entered; request arriving in S_SG -> no walk
//    this cycle, walk on the next cycle
//  4 global_reset pulsed at walk tick 2 -> next edge main=001, side=100, walk_lamp=0, rem=6;
//    tick asserted with reset -> ignored
//  5 TRAFFIC_SENSOR_EN, sensor=1 at SG expiry -> side green lasts 9 ticks total; sensor=0 -> 6 ticks
//  6 tick held low for 100 clocks in every state -> no state or output change

Source files
------------

// File: rtl/traffic_light_fsm.sv
// rtl/traffic_light_fsm.sv - intersection lamp sequencer driven by a 1 Hz tick
//
// Optional side-street vehicle sensor: define TRAFFIC_SENSOR_EN to add the
// sensor port and the side-green extension phase (S_SGX). Without it the
// extension phase is unreachable and side green always runs T_BASE ticks.

module traffic_light_fsm #(
  parameter int T_BASE = 6,
  parameter int T_EXT  = 3,
  parameter int T_YEL  = 2,
  parameter int CNT_W  = 4
) (
  input  logic       clk,
  input  logic       global_reset,
  input  logic       tick,
  input  logic       wr_to_fsm,
`ifdef TRAFFIC_SENSOR_EN
  input  logic       sensor,
`endif
  output logic [2:0] main_rgy,
  output logic [2:0] side_rgy,
  output logic       walk_lamp,
  output logic       walk_request_reset
);

  // Lamp encodings, one-hot {R,Y,G}
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Phase durations in ticks, sized to the timer
  localparam logic [CNT_W-1:0] D_BASE = CNT_W'(T_BASE);
  localparam logic [CNT_W-1:0] D_EXT  = CNT_W'(T_EXT);
  localparam logic [CNT_W-1:0] D_YEL  = CNT_W'(T_YEL);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_MG   = 3'd0,
    S_MY   = 3'd1,
    S_WALK = 3'd2,
    S_SG   = 3'd3,
    S_SGX  = 3'd4,
    S_SY   = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  state_t           succ;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] rem_nxt;
  logic             illegal;
  logic             side_demand;

`ifdef TRAFFIC_SENSOR_EN
  assign side_demand = sensor;
`else
  // No sensor fitted: side street never asks for the extension
  assign side_demand = 1'b0;
`endif

  // Duration loaded into the timer when a state is entered
  function automatic logic [CNT_W-1:0] dur_of(input state_t s);
    case (s)
      S_MG:    dur_of = D_BASE;
      S_MY:    dur_of = D_YEL;
      S_WALK:  dur_of = D_EXT;
      S_SG:    dur_of = D_BASE;
      S_SGX:   dur_of = D_EXT;
      S_SY:    dur_of = D_YEL;
      default: dur_of = D_BASE;
    endcase
  endfunction

  // State and timer register; reset wins over tick and every transition
  always_ff @(posedge clk) begin
    if (global_reset) begin
      state <= S_MG;
      rem   <= D_BASE;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // Successor selection and timer update; only a tick moves time forward
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    succ      = S_MG;
    illegal   = 1'b0;

    case (state)
      S_MG:    succ = S_MY;
      S_MY:    succ = wr_to_fsm ? S_WALK : S_SG;
      S_WALK:  succ = S_SG;
      S_SG:    succ = side_demand ? S_SGX : S_SY;
      S_SGX:   succ = S_SY;
      S_SY:    succ = S_MG;
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      // Corrupted encoding: restart the cycle from main green
      state_nxt = S_MG;
      rem_nxt   = D_BASE;
    end else if (tick) begin
      if (rem > ONE) begin
        rem_nxt = rem - ONE;
      end else begin
        // A zero count can only come from corruption; expire it like a one
        state_nxt = succ;
        rem_nxt   = dur_of(succ);
      end
    end
  end

  // Moore lamp decode; unknown encodings show all-red
  always_comb begin
    main_rgy           = LAMP_R;
    side_rgy           = LAMP_R;
    walk_lamp          = 1'b0;
    walk_request_reset = 1'b0;
    case (state)
      S_MG: begin
        main_rgy = LAMP_G;
      end
      S_MY: begin
        main_rgy = LAMP_Y;
      end
      S_WALK: begin
        walk_lamp          = 1'b1;
        walk_request_reset = 1'b1;
      end
      S_SG: begin
        side_rgy = LAMP_G;
      end
      S_SGX: begin
        side_rgy = LAMP_G;
      end
      S_SY: begin
        side_rgy = LAMP_Y;
      end
      default: begin
        main_rgy = LAMP_R;
        side_rgy = LAMP_R;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb/tb_traffic_light_fsm.sv - scoreboard bench for traffic_light_fsm

module tb_traffic_light_fsm;

  localparam int MG = 0;
  localparam int MY = 1;
  localparam int WK = 2;
  localparam int SG = 3;
  localparam int SX = 4;
  localparam int SY = 5;

  typedef struct packed {
    logic [2:0] m;
    logic [2:0] s;
    logic       w;
    logic       r;
    logic [3:0] rem;
  } exp_t;

  logic       clk = 1'b0;
  logic       global_reset = 1'b1;
  logic       tick = 1'b0;
  logic       wr_pulse = 1'b0;
  logic       wr_q = 1'b0;
  logic       wr_to_fsm;
  logic       probe = 1'b0;
  logic [2:0] main_rgy;
  logic [2:0] side_rgy;
  logic       walk_lamp;
  logic       walk_request_reset;
`ifdef TRAFFIC_SENSOR_EN
  logic       sensor = 1'b0;
`endif

  exp_t  q[$];
  string tq[$];
  int    errors = 0;
  int    checks = 0;
  int    wrr_clocks = 0;
  logic  count_wrr = 1'b0;
  bit    long_gap = 1'b0;

  always #5 clk = ~clk;

  traffic_light_fsm dut (
    .clk                (clk),
    .global_reset       (global_reset),
    .tick               (tick),
    .wr_to_fsm          (wr_to_fsm),
`ifdef TRAFFIC_SENSOR_EN
    .sensor             (sensor),
`endif
    .main_rgy           (main_rgy),
    .side_rgy           (side_rgy),
    .walk_lamp          (walk_lamp),
    .walk_request_reset (walk_request_reset)
  );

  // Walk register model: a pulse is visible at once and held until served
  assign wr_to_fsm = wr_q | wr_pulse;
  always @(posedge clk) begin
    if (global_reset || walk_request_reset) wr_q <= 1'b0;
    else if (wr_pulse) wr_q <= 1'b1;
  end

  // Monitor: on every tick or probe cycle compare against the next expectation
  always @(negedge clk) begin
    exp_t  got;
    exp_t  e;
    string t;
    if (count_wrr && walk_request_reset) wrr_clocks++;
    if (tick || probe) begin
      got = {main_rgy, side_rgy, walk_lamp, walk_request_reset, dut.rem};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow got=%h", got);
      end else begin
        e = q.pop_front();
        t = tq.pop_front();
        if (got !== e)
          begin
            errors++;
            $display("FAIL %s got m=%b s=%b w=%b r=%b rem=%0d exp m=%b s=%b w=%b r=%b rem=%0d",
                     t, got.m, got.s, got.w, got.r, got.rem, e.m, e.s, e.w, e.r, e.rem);
          end
      end
    end
  end

  function automatic exp_t mk(input int ph, input int r);
    exp_t e;
    case (ph)
      MG:      e = {3'b001, 3'b100, 1'b0, 1'b0, 4'(r)};
      MY:      e = {3'b010, 3'b100, 1'b0, 1'b0, 4'(r)};
      WK:      e = {3'b100, 3'b100, 1'b1, 1'b1, 4'(r)};
      SG:      e = {3'b100, 3'b001, 1'b0, 1'b0, 4'(r)};
      SX:      e = {3'b100, 3'b001, 1'b0, 1'b0, 4'(r)};
      default: e = {3'b100, 3'b010, 1'b0, 1'b0, 4'(r)};
    endcase
    return e;
  endfunction

  task automatic push(input exp_t e, input string t);
    q.push_back(e);
    tq.push_back(t);
  endtask

  // One tick period: idle clocks (with a mid-gap probe in long mode), then the tick cycle
  task automatic tick_cycle(input bit pulse, input bit rst);
    if (long_gap) begin
      repeat (48) @(posedge clk);
      #1 probe = 1'b1;
      @(posedge clk);
      #1 probe = 1'b0;
      repeat (50) @(posedge clk);
    end else begin
      repeat (3) @(posedge clk);
    end
    #1;
    tick         = 1'b1;
    wr_pulse     = pulse;
    global_reset = rst;
    @(posedge clk);
    #1;
    tick         = 1'b0;
    wr_pulse     = 1'b0;
    global_reset = 1'b0;
  endtask

  // Expect a whole phase of d ticks; pulse the walk request on tick index pulse_at
  task automatic phase(input int ph, input int d, input int pulse_at, input string t);
    for (int k = 0; k < d; k++) begin
      if (long_gap) push(mk(ph, d - k), {t, "_hold"});
      push(mk(ph, d - k), t);
      tick_cycle(k == pulse_at, 1'b0);
    end
  endtask

  task automatic probe_cycle();
    probe = 1'b1;
    @(posedge clk);
    #1 probe = 1'b0;
  endtask

  task automatic do_reset(input string t);
    @(posedge clk);
    #1 global_reset = 1'b1;
    tick = 1'b0;
    repeat (2) @(posedge clk);
    #1 global_reset = 1'b0;
    push(mk(MG, 6), t);
    probe_cycle();
  endtask

  initial begin
    repeat (2) @(posedge clk);

    // 1: no requests, plain 16-tick period twice
    do_reset("s1_reset");
    for (int p = 0; p < 2; p++) begin
      phase(MG, 6, -1, "s1_mg");
      phase(MY, 2, -1, "s1_my");
      phase(SG, 6, -1, "s1_sg");
      phase(SY, 2, -1, "s1_sy");
    end

    // 2: request from MG tick 3, 19-tick period, request cleared after walk
    do_reset("s2_reset");
    count_wrr = 1'b1;
    phase(MG, 6, 2, "s2_mg");
    phase(MY, 2, -1, "s2_my");
    phase(WK, 3, -1, "s2_walk");
    phase(SG, 6, -1, "s2_sg");
    phase(SY, 2, -1, "s2_sy");
    phase(MG, 6, -1, "s2_mg2");
    phase(MY, 2, -1, "s2_my2");
    phase(SG, 6, -1, "s2_sg2");
    count_wrr = 1'b0;
    checks++;
    if (wrr_clocks != 12) begin
      errors++;
      $display("FAIL s2_wrr_clocks got=%0d exp=12", wrr_clocks);
    end

    // 3: request in the MY expiry cycle, then a request raised during SG
    do_reset("s3_reset");
    phase(MG, 6, -1, "s3_mg");
    phase(MY, 2, 1, "s3_my_edge");
    phase(WK, 3, -1, "s3_walk");
    phase(SG, 6, 1, "s3_sg_req");
    phase(SY, 2, -1, "s3_sy");
    phase(MG, 6, -1, "s3_mg2");
    phase(MY, 2, -1, "s3_my2");
    phase(WK, 3, -1, "s3_walk2");
    phase(SG, 6, -1, "s3_sg2");

    // 4: reset together with tick at walk tick 2
    do_reset("s4_reset");
    phase(MG, 6, 2, "s4_mg");
    phase(MY, 2, -1, "s4_my");
    push(mk(WK, 3), "s4_walk1");
    tick_cycle(1'b0, 1'b0);
    push(mk(WK, 2), "s4_walk2_rst");
    tick_cycle(1'b0, 1'b1);
    push(mk(MG, 6), "s4_after_rst");
    probe_cycle();
    phase(MG, 6, -1, "s4_mg2");
    phase(MY, 2, -1, "s4_my2");
    phase(SG, 6, -1, "s4_sg2");

`ifdef TRAFFIC_SENSOR_EN
    // 5: sensor extends side green by T_EXT, then no extension
    do_reset("s5_reset");
    sensor = 1'b1;
    phase(MG, 6, -1, "s5_mg");
    phase(MY, 2, -1, "s5_my");
    phase(SG, 6, -1, "s5_sg");
    phase(SX, 3, -1, "s5_sgx");
    sensor = 1'b0;
    phase(SY, 2, -1, "s5_sy");
    phase(MG, 6, -1, "s5_mg2");
    phase(MY, 2, -1, "s5_my2");
    phase(SG, 6, -1, "s5_sg2");
    phase(SY, 2, -1, "s5_sy2");
`endif

    // 6: ~100 idle clocks between ticks in every state, walk included
    do_reset("s6_reset");
    long_gap = 1'b1;
    phase(MG, 6, 0, "s6_mg");
    phase(MY, 2, -1, "s6_my");
    phase(WK, 3, -1, "s6_walk");
    phase(SG, 6, -1, "s6_sg");
    phase(SY, 2, -1, "s6_sy");
    long_gap = 1'b0;

    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
